// File: rtl/miriscv_mdu_pkg.sv
// Multiply/divide unit opcodes and divider FSM encodings shared by the execute stage.
// Opcodes match the decode-stage encoding of the RV32M divide group.
package miriscv_mdu_pkg;

    localparam int MDU_OP_W = 2;

    localparam logic [MDU_OP_W-1:0] MDU_DIV  = 2'b00;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU = 2'b01;
    localparam logic [MDU_OP_W-1:0] MDU_REM  = 2'b10;
    localparam logic [MDU_OP_W-1:0] MDU_REMU = 2'b11;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'b00;
    localparam div_state_t DIV_CALC = 2'b01;
    localparam div_state_t DIV_DONE = 2'b10;

endpackage

// File: rtl/miriscv_div_if.sv
// Request/valid bundle between the execute stage and the iterative divider.
// master = execute stage, slave = divider.
interface miriscv_div_if #(
    parameter int XLEN = 32
);
    import miriscv_mdu_pkg::*;

    logic                div_req_i;
    logic [MDU_OP_W-1:0] div_op_i;
    logic [XLEN-1:0]     div_port_a_i;
    logic [XLEN-1:0]     div_port_b_i;
    logic                kill_i;
    logic                div_busy_o;
    logic                div_valid_o;
    logic [XLEN-1:0]     div_result_o;

    modport master (
        output div_req_i, div_op_i, div_port_a_i, div_port_b_i, kill_i,
        input  div_busy_o, div_valid_o, div_result_o
    );

    modport slave (
        input  div_req_i, div_op_i, div_port_a_i, div_port_b_i, kill_i,
        output div_busy_o, div_valid_o, div_result_o
    );

endinterface

// File: rtl/miriscv_div.sv
// Iterative radix-2 restoring divider for RV32M: XLEN+1 cycles normally, 1 cycle for /0 and overflow.
// Requests are only taken in IDLE; the execute stage stalls on div_busy_o, kill_i aborts at any time.
module miriscv_div
    import miriscv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    miriscv_div_if.slave  div_bus
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [MDU_OP_W-1:0] op_q;
    logic                neg_quo;
    logic                neg_rem;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     b_abs;
    logic [XLEN-1:0]     result_q;

    logic            in_signed;
    logic            in_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs_in;
    logic [XLEN-1:0] b_abs_in;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        in_signed = (div_bus.div_op_i == MDU_DIV) || (div_bus.div_op_i == MDU_REM);
        in_rem    = (div_bus.div_op_i == MDU_REM) || (div_bus.div_op_i == MDU_REMU);
        a_neg     = in_signed && div_bus.div_port_a_i[XLEN-1];
        b_neg     = in_signed && div_bus.div_port_b_i[XLEN-1];
        a_abs_in  = a_neg ? -div_bus.div_port_a_i : div_bus.div_port_a_i;
        b_abs_in  = b_neg ? -div_bus.div_port_b_i : div_bus.div_port_b_i;
        div_zero  = (div_bus.div_port_b_i == '0);
        overflow  = in_signed && (div_bus.div_port_a_i == INT_MIN)
                              && (div_bus.div_port_b_i == {XLEN{1'b1}});
        // Divide-by-zero takes precedence; overflow can only occur with a non-zero divisor.
        if (div_zero) begin
            fast_res = in_rem ? div_bus.div_port_a_i : {XLEN{1'b1}};
        end else begin
            fast_res = in_rem ? '0 : INT_MIN;
        end
    end

    logic [XLEN:0]   rem_ext;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] calc_res;

    always_comb begin
        rem_ext = {rem_q, quo_q[XLEN-1]};
        trial   = rem_ext - {1'b0, b_abs};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = rem_ext[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end
        // Sign fix applies to the value produced by the final step.
        if ((op_q == MDU_REM) || (op_q == MDU_REMU)) begin
            calc_res = neg_rem ? -rem_nxt : rem_nxt;
        end else begin
            calc_res = neg_quo ? -quo_nxt : quo_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            op_q     <= MDU_DIV;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_abs    <= '0;
            result_q <= '0;
        end else if (div_bus.kill_i) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_bus.div_req_i) begin
                        op_q    <= div_bus.div_op_i;
                        neg_quo <= (div_bus.div_op_i == MDU_DIV) && (a_neg != b_neg);
                        neg_rem <= (div_bus.div_op_i == MDU_REM) && a_neg;
                        rem_q   <= '0;
                        quo_q   <= a_abs_in;
                        b_abs   <= b_abs_in;
                        if (div_zero || overflow) begin
                            result_q <= fast_res;
                            state    <= DIV_DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN - 1);
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt == '0) begin
                        result_q <= calc_res;
                        state    <= DIV_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign div_bus.div_busy_o   = (state != DIV_IDLE);
    assign div_bus.div_valid_o  = (state == DIV_DONE) && !div_bus.kill_i;
    assign div_bus.div_result_o = result_q;

endmodule

// File: tb/tb_miriscv_div.sv
// Directed-vector bench for miriscv_div: normal, fast-path, kill, ignored-request and reset cases.
// All activity is aligned to 1 time unit after the rising edge.
module tb_miriscv_div;
    import miriscv_mdu_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    miriscv_div_if #(.XLEN(32)) div_bus ();

    miriscv_div #(.XLEN(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .div_bus (div_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a request in the current cycle; returns in cycle 1 of the op.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_bus.div_req_i    = 1'b1;
        div_bus.div_op_i     = op;
        div_bus.div_port_a_i = a;
        div_bus.div_port_b_i = b;
        tick();
        div_bus.div_req_i = 1'b0;
    endtask

    // Starting from cycle 1, advances until div_valid_o and reports the cycle it appeared in.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!div_bus.div_valid_o && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int cyc;
        start_op(op, a, b);
        wait_valid(cyc);
        chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_result"}, div_bus.div_result_o, exp_res);
        tick();
        chk({tag, "_pulse_end"}, {31'd0, div_bus.div_valid_o}, 32'd0);
        chk({tag, "_idle"}, {31'd0, div_bus.div_busy_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] held;

        div_bus.div_req_i    = 1'b0;
        div_bus.div_op_i     = MDU_DIV;
        div_bus.div_port_a_i = '0;
        div_bus.div_port_b_i = '0;
        div_bus.kill_i       = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        chk("rst_busy", {31'd0, div_bus.div_busy_o}, 32'd0);
        chk("rst_valid", {31'd0, div_bus.div_valid_o}, 32'd0);
        chk("rst_result", div_bus.div_result_o, 32'd0);

        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("remu_big_2", MDU_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
        run_op("div_m100_m7", MDU_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
        run_op("divu_max_1", MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("div_by0", MDU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", MDU_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Kill in cycle 10, then a fresh request accepted at cycle 11.
        held = div_bus.div_result_o;
        start_op(MDU_DIVU, 32'd1000, 32'd10);
        repeat (9) tick();
        chk("kill_busy_before", {31'd0, div_bus.div_busy_o}, 32'd1);
        div_bus.kill_i = 1'b1;
        tick();
        div_bus.kill_i = 1'b0;
        chk("kill_busy_after", {31'd0, div_bus.div_busy_o}, 32'd0);
        chk("kill_valid_after", {31'd0, div_bus.div_valid_o}, 32'd0);
        chk("kill_result_held", div_bus.div_result_o, held);
        run_op("divu_9_3_after_kill", MDU_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // A request alongside kill in IDLE is dropped.
        div_bus.kill_i = 1'b1;
        start_op(MDU_DIVU, 32'd8, 32'd2);
        div_bus.kill_i = 1'b0;
        chk("kill_req_dropped", {31'd0, div_bus.div_busy_o}, 32'd0);

        // Kill during DONE suppresses the pulse.
        start_op(MDU_DIV, 32'd5, 32'd0);
        div_bus.kill_i = 1'b1;
        #1;
        chk("kill_done_valid", {31'd0, div_bus.div_valid_o}, 32'd0);
        tick();
        div_bus.kill_i = 1'b0;
        chk("kill_done_idle", {31'd0, div_bus.div_busy_o}, 32'd0);
        chk("kill_done_no_late", {31'd0, div_bus.div_valid_o}, 32'd0);

        // Request in cycle 5 of a running op is ignored.
        start_op(MDU_DIVU, 32'd50, 32'd5);
        repeat (4) tick();
        start_op(MDU_DIVU, 32'd7, 32'd7);
        cyc = 6;
        while (!div_bus.div_valid_o && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("ignored_req_cycle", 32'(cyc), 32'd33);
        chk("ignored_req_result", div_bus.div_result_o, 32'd10);
        tick();
        chk("ignored_req_idle", {31'd0, div_bus.div_busy_o}, 32'd0);

        // Reset in cycle 20, then a request in cycle 21.
        start_op(MDU_DIVU, 32'd1000, 32'd10);
        repeat (19) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_busy", {31'd0, div_bus.div_busy_o}, 32'd0);
        chk("midrst_valid", {31'd0, div_bus.div_valid_o}, 32'd0);
        chk("midrst_result", div_bus.div_result_o, 32'd0);
        run_op("rem_17_m5_after_rst", MDU_REM, 32'd17, 32'hFFFF_FFFB, 32'd2, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
